// File: rtl/data_sync_filter.sv
// Multi-channel input conditioner. Each bit goes through a synchroniser chain,
// then a stability filter that commits only after F_CYCLES consecutive mismatches.
`timescale 1ns/100ps

module data_sync_filter_lane #(
  parameter int   S_STAGES = 2,
  parameter int   F_CYCLES = 4,
  parameter int   CW       = 2,
  parameter logic INIT_BIT = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic data_o,
  output logic rise_o,
  output logic fall_o,
  output logic commit_o
);
  localparam logic [CW-1:0] LAST = CW'(F_CYCLES - 1);

  logic [S_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                data_q, data_d;
  logic                rise_q, rise_d;
  logic                fall_q, fall_d;
  logic                s;

  assign sync_d = {sync_q[S_STAGES-2:0], d_i};
  assign s      = sync_q[S_STAGES-1];

  always_comb begin
    cnt_d    = cnt_q;
    data_d   = data_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    commit_o = 1'b0;
    if (s == data_q) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      commit_o = 1'b1;
      data_d   = s;
      cnt_d    = '0;
      rise_d   = s;
      fall_d   = ~s;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync_q <= {S_STAGES{INIT_BIT}};
      cnt_q  <= '0;
      data_q <= INIT_BIT;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign data_o = data_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
endmodule

module data_sync_filter #(
  parameter int                 D_WIDTH  = 8,
  parameter int                 S_STAGES = 2,
  parameter int                 F_CYCLES = 4,
  parameter logic [D_WIDTH-1:0] INIT_VAL = '0
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [D_WIDTH-1:0] data_i,
  output logic [D_WIDTH-1:0] data_o,
  output logic [D_WIDTH-1:0] rise_o,
  output logic [D_WIDTH-1:0] fall_o,
  output logic               chg_o
);
  localparam int CW = (F_CYCLES > 1) ? $clog2(F_CYCLES) : 1;

  if (S_STAGES < 2) begin : g_bad_stages
    $error("data_sync_filter: S_STAGES must be >= 2");
  end
  if (F_CYCLES < 1) begin : g_bad_cycles
    $error("data_sync_filter: F_CYCLES must be >= 1");
  end

  logic [D_WIDTH-1:0] commit;
  logic               chg_q, chg_d;

  for (genvar g = 0; g < D_WIDTH; g++) begin : g_lane
    data_sync_filter_lane #(
      .S_STAGES (S_STAGES),
      .F_CYCLES (F_CYCLES),
      .CW       (CW),
      .INIT_BIT (INIT_VAL[g])
    ) u_lane (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .d_i      (data_i[g]),
      .data_o   (data_o[g]),
      .rise_o   (rise_o[g]),
      .fall_o   (fall_o[g]),
      .commit_o (commit[g])
    );
  end

  // Every commit produces exactly one rise or fall, so OR of commits is chg.
  assign chg_d = |commit;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) chg_q <= 1'b0;
    else          chg_q <= chg_d;
  end

  assign chg_o = chg_q;
endmodule

// File: tb/tb_data_sync_filter.sv
// Directed and randomised checks of data_sync_filter (8 ch, 2 sync stages, 4-cycle filter).
`timescale 1ns/100ps

module tb_data_sync_filter;
  localparam int F = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_i;
  logic [7:0] data_o, rise_o, fall_o;
  logic       chg_o;

  int nvec = 0;
  int nerr = 0;

  data_sync_filter #(
    .D_WIDTH  (8),
    .S_STAGES (2),
    .F_CYCLES (F),
    .INIT_VAL (8'h00)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .data_i  (data_i),
    .data_o  (data_o),
    .rise_o  (rise_o),
    .fall_o  (fall_o),
    .chg_o   (chg_o)
  );

  always #2.5 clk = ~clk;

  // Reference model: run-length of consecutive mismatches per channel.
  logic [7:0] m_s1, m_s2, m_data, m_rise, m_fall;
  int         m_run [8];

  always @(posedge clk) begin
    if (!rst_n) begin
      m_s1 <= 8'h00; m_s2 <= 8'h00; m_data <= 8'h00;
      m_rise <= 8'h00; m_fall <= 8'h00;
      for (int b = 0; b < 8; b++) m_run[b] <= 0;
    end else begin
      m_s1 <= data_i;
      m_s2 <= m_s1;
      for (int b = 0; b < 8; b++) begin
        m_rise[b] <= 1'b0;
        m_fall[b] <= 1'b0;
        if (m_s2[b] == m_data[b]) m_run[b] <= 0;
        else if (m_run[b] + 1 >= F) begin
          m_data[b] <= m_s2[b];
          m_rise[b] <= m_s2[b];
          m_fall[b] <= ~m_s2[b];
          m_run[b]  <= 0;
        end else m_run[b] <= m_run[b] + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_all(input string tag, input logic [7:0] d, input logic [7:0] r,
                         input logic [7:0] f, input logic c);
    chk({tag, ".data"}, {24'h0, data_o}, {24'h0, d});
    chk({tag, ".rise"}, {24'h0, rise_o}, {24'h0, r});
    chk({tag, ".fall"}, {24'h0, fall_o}, {24'h0, f});
    chk({tag, ".chg"},  {31'h0, chg_o},  {31'h0, c});
  endtask

  logic [7:0] prev_rise, prev_fall;

  initial begin
    // 1. Reset held with non-zero input
    rst_n  = 1'b0;
    data_i = 8'hA5;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk_all("reset", 8'h00, 8'h00, 8'h00, 1'b0);
    end
    data_i = 8'h00;
    rst_n  = 1'b1;
    cyc(4);
    chk_all("idle", 8'h00, 8'h00, 8'h00, 1'b0);

    // 2. Step 00 -> FF, commit on edge 6
    data_i = 8'hFF;
    for (int e = 1; e <= 5; e++) begin
      cyc(1);
      chk_all("step.pre", 8'h00, 8'h00, 8'h00, 1'b0);
    end
    cyc(1);
    chk_all("step.commit", 8'hFF, 8'hFF, 8'h00, 1'b1);
    cyc(1);
    chk_all("step.post", 8'hFF, 8'h00, 8'h00, 1'b0);

    // 3a. Glitch of 3 samples on bit0 is absorbed
    data_i = 8'h00;
    cyc(10);
    chk_all("glitch.base", 8'h00, 8'h00, 8'h00, 1'b0);
    data_i = 8'h01;
    for (int e = 1; e <= 12; e++) begin
      cyc(1);
      if (e == 3) data_i = 8'h00;
      chk_all("glitch3", 8'h00, 8'h00, 8'h00, 1'b0);
    end

    // 3b. Glitch of 4 samples on bit0 commits on edge 6
    data_i = 8'h01;
    for (int e = 1; e <= 5; e++) begin
      cyc(1);
      if (e == 4) data_i = 8'h00;
      chk_all("glitch4.pre", 8'h00, 8'h00, 8'h00, 1'b0);
    end
    cyc(1);
    chk_all("glitch4.commit", 8'h01, 8'h01, 8'h00, 1'b1);
    cyc(1);
    chk_all("glitch4.post", 8'h01, 8'h00, 8'h00, 1'b0);
    cyc(10);

    // 4. Mixed rise/fall in one cycle
    data_i = 8'hF0;
    cyc(10);
    chk_all("mixed.base", 8'hF0, 8'h00, 8'h00, 1'b0);
    data_i = 8'h0F;
    cyc(5);
    chk_all("mixed.pre", 8'hF0, 8'h00, 8'h00, 1'b0);
    cyc(1);
    chk_all("mixed.commit", 8'h0F, 8'h0F, 8'hF0, 1'b1);
    cyc(1);
    chk_all("mixed.post", 8'h0F, 8'h00, 8'h00, 1'b0);

    // 5. Reset mid-step discards the pending change
    data_i = 8'h00;
    cyc(10);
    chk_all("rstmid.base", 8'h00, 8'h00, 8'h00, 1'b0);
    data_i = 8'hFF;
    cyc(3);
    rst_n = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      cyc(1);
      if (e == 2) rst_n = 1'b1;
      chk_all("rstmid.hold", 8'h00, 8'h00, 8'h00, 1'b0);
    end
    // edges 1,2 after release already counted above; 3 more pre-commit edges
    cyc(3);
    chk_all("rstmid.pre", 8'h00, 8'h00, 8'h00, 1'b0);
    cyc(1);
    chk_all("rstmid.commit", 8'hFF, 8'hFF, 8'h00, 1'b1);
    cyc(1);
    chk_all("rstmid.post", 8'hFF, 8'h00, 8'h00, 1'b0);

    // 6. Random input off the clock grid, checked against the model every cycle
    prev_rise = 8'h00;
    prev_fall = 8'h00;
    fork
      begin
        #0.2;
        for (int i = 0; i < 64; i++) begin
          data_i = 8'($urandom);
          #3;
        end
      end
      begin
        for (int c = 0; c < 90; c++) begin
          cyc(1);
          chk_all("rand", m_data, m_rise, m_fall, |(m_rise | m_fall));
          chk("rand.width", {16'h0, rise_o & prev_rise, fall_o & prev_fall}, 32'h0);
          chk("rand.excl", {24'h0, rise_o & fall_o}, 32'h0);
          prev_rise = rise_o;
          prev_fall = fall_o;
        end
      end
    join
    chk("rand.final", {24'h0, data_o}, {24'h0, data_i});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
